dsp_frame_packer: RTL and testbench

//  Consumer end of the decimated IQ stream: takes IQ/TIME samples with valid, interval number and

---
 rtl/dsp_pkg.sv | 54 +++++
 rtl/dsp_sync_fifo.sv | 73 +++++++
 rtl/dsp_frame_packer.sv | 243 ++++++++++++++++++++++++
 tb/tb_dsp_frame_packer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared types and constants for the IQ frame packer.
//   pack_state_e : packer FSM states
//   PACK_SYNC    : sync pattern in the upper half of the first header word
//   TRL_*        : trailer word bit positions
//   sample_t     : one buffered sample {iq, stime, inter}
//   csum_step    : one checksum accumulation step over an IQ word
//   make_trailer : assembles the trailer word from its fields
// ---------------------------------------------------------------------------
package dsp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        TRL  = 3'd4
    } pack_state_e;

    localparam logic [15:0] PACK_SYNC = 16'hA5C3;

    localparam int TRL_OVF   = 15;
    localparam int TRL_TMO   = 14;
    localparam int TRL_CNT_W = 12;

    // "time" is a reserved word, hence stime for the sample timestamp.
    typedef struct packed {
        logic [31:0] iq;
        logic [31:0] stime;
        logic [15:0] inter;
    } sample_t;

    // Modulo-2^16 sum of both IQ halves added to the running checksum.
    function automatic logic [15:0] csum_step(input logic [15:0] acc,
                                              input logic [31:0] iq);
        return acc + iq[31:16] + iq[15:0];
    endfunction

    // Trailer layout: [31:16] checksum, [15] ovf, [14] tmo, [13:12] zero, [11:0] count.
    function automatic logic [31:0] make_trailer(input logic [15:0]          csum,
                                                 input logic                 ovf,
                                                 input logic                 tmo,
                                                 input logic [TRL_CNT_W-1:0] cnt);
        logic [31:0] w;
        w                  = 32'h0000_0000;
        w[31:16]           = csum;
        w[TRL_OVF]         = ovf;
        w[TRL_TMO]         = tmo;
        w[TRL_CNT_W-1:0]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/dsp_sync_fifo.sv
// ---------------------------------------------------------------------------
// dsp_sync_fifo
// Single-clock show-ahead FIFO: the oldest entry is always present on
// rd_data while empty is low; a write becomes visible at the head on the
// following cycle. A write on a full FIFO is accepted only when a read
// frees a slot in the same cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write strobe and data
//   rd_en             pop the head entry
//   rd_data           head entry (show-ahead)
//   full, empty       occupancy flags
// ---------------------------------------------------------------------------
module dsp_sync_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             full_s;
    logic             empty_s;

    // Occupancy flags from the extra pointer wrap bit, and gated strobes.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        rd_ok_s = rd_en && !empty_s;
        wr_ok_s = wr_en && (!full_s || rd_ok_s);
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since the pointers guard every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/dsp_frame_packer.sv
// ---------------------------------------------------------------------------
// dsp_frame_packer
// Buffers decimated IQ/TIME samples and emits them as framed 32-bit words on
// a valid/ready stream:
//   HDR0 {A5C3, interval}, HDR1 first-sample time, IQ words, trailer.
// A frame closes on FRAME_LEN words, an interval change at the FIFO head,
// an empty FIFO while in_clr is high, or TIMEOUT empty cycles.
// Build option: define DSP_PACK_CSUM_EN to place a 16-bit IQ checksum in the
// trailer upper half (otherwise those bits are zero and no adder is built).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_iq, in_time, in_inter   sample fields, captured when in_valid is high
//   in_valid                   sample strobe (no backpressure)
//   in_clr                     upstream disabled / time-clear level
//   m_data, m_valid, m_ready   output stream, m_last marks the trailer
//   drop_cnt                   samples lost on a full FIFO (saturating)
//   frame_cnt                  trailers transferred (wrapping)
//   busy                       frame in progress or samples buffered
// ---------------------------------------------------------------------------
module dsp_frame_packer
    import dsp_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int FRAME_LEN  = 256,
    parameter int TIMEOUT    = 4800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_iq,
    input  logic [31:0] in_time,
    input  logic        in_valid,
    input  logic [15:0] in_inter,
    input  logic        in_clr,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] drop_cnt,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int                     SW          = $bits(sample_t);
    localparam int                     IDLE_W      = $clog2(TIMEOUT + 1);
    localparam logic [TRL_CNT_W-1:0]   FRAME_LEN_C = TRL_CNT_W'(FRAME_LEN);
    localparam logic [IDLE_W-1:0]      TMO_LAST_C  = IDLE_W'(TIMEOUT - 1);

    pack_state_e          state_r;
    logic [31:0]          m_data_r;
    logic                 m_valid_r;
    logic                 m_last_r;
    logic [15:0]          drop_cnt_r;
    logic [15:0]          frame_cnt_r;
    logic                 ovf_r;
    logic [15:0]          frame_inter_r;
    logic [TRL_CNT_W-1:0] count_r;
    logic [IDLE_W-1:0]    idle_cnt_r;

    logic [SW-1:0]        fifo_rdata_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    sample_t              head_s;
    logic                 slot_free_s;
    logic                 xfer_s;
    logic                 in_data_s;
    logic                 full_frame_s;
    logic                 inter_chg_s;
    logic                 clr_close_s;
    logic                 tmo_close_s;
    logic                 tmo_flag_s;
    logic                 close_s;
    logic                 pop_s;
    logic                 wr_s;
    logic                 drop_s;
    logic [15:0]          csum_s;

    dsp_sync_fifo #(
        .WIDTH (SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_s),
        .wr_data ({in_iq, in_time, in_inter}),
        .rd_en   (pop_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Per-cycle decisions: output slot availability, frame close reasons, pop/write/drop.
    always_comb begin
        head_s       = sample_t'(fifo_rdata_s);
        slot_free_s  = !m_valid_r || m_ready;
        xfer_s       = m_valid_r && m_ready;
        in_data_s    = (state_r == DATA) && slot_free_s;
        full_frame_s = (count_r == FRAME_LEN_C);
        // A sample from a new interval stays at the head and opens the next frame.
        inter_chg_s  = !fifo_empty_s && (head_s.inter != frame_inter_r);
        clr_close_s  = fifo_empty_s && in_clr;
        tmo_close_s  = fifo_empty_s && !in_clr && (idle_cnt_r == TMO_LAST_C);
        close_s      = in_data_s && (full_frame_s || inter_chg_s || clr_close_s || tmo_close_s);
        tmo_flag_s   = tmo_close_s && !full_frame_s;
        pop_s        = in_data_s && !full_frame_s && !fifo_empty_s && !inter_chg_s;
        // A pop in the same cycle frees a slot, so a write on a full FIFO still lands.
        wr_s         = in_valid && (!fifo_full_s || pop_s);
        drop_s       = in_valid && fifo_full_s && !pop_s;
    end

`ifdef DSP_PACK_CSUM_EN
    logic [15:0] csum_r;

    // Running IQ checksum, restarted whenever a new frame opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= 16'h0000;
        end else if ((state_r == IDLE) && !fifo_empty_s) begin
            csum_r <= 16'h0000;
        end else if (pop_s) begin
            csum_r <= csum_step(csum_r, head_s.iq);
        end else begin
            csum_r <= csum_r;
        end
    end

    assign csum_s = csum_r;
`else
    assign csum_s = 16'h0000;
`endif

    // Packer FSM with the registered output word, valid and last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            m_data_r      <= 32'h0000_0000;
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
            frame_inter_r <= 16'h0000;
            count_r       <= {TRL_CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        m_data_r      <= {PACK_SYNC, head_s.inter};
                        m_valid_r     <= 1'b1;
                        m_last_r      <= 1'b0;
                        frame_inter_r <= head_s.inter;
                        count_r       <= {TRL_CNT_W{1'b0}};
                        state_r       <= HDR0;
                    end
                end
                HDR0: begin
                    // The head is only peeked here; it is popped as the first IQ word.
                    if (xfer_s) begin
                        m_data_r <= head_s.stime;
                        state_r  <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer_s) begin
                        m_valid_r <= 1'b0;
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (close_s) begin
                        m_data_r  <= make_trailer(csum_s, ovf_r, tmo_flag_s, count_r);
                        m_valid_r <= 1'b1;
                        m_last_r  <= 1'b1;
                        state_r   <= TRL;
                    end else if (pop_s) begin
                        m_data_r  <= head_s.iq;
                        m_valid_r <= 1'b1;
                        count_r   <= count_r + TRL_CNT_W'(1);
                    end else if (slot_free_s) begin
                        m_valid_r <= 1'b0;
                    end
                end
                TRL: begin
                    if (xfer_s) begin
                        m_valid_r <= 1'b0;
                        m_last_r  <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Empty-FIFO cycle counter inside DATA; saturates at the close threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if ((state_r == DATA) && fifo_empty_s && !wr_s) begin
            if (idle_cnt_r != TMO_LAST_C) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end
        end else begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end
    end

    // Sticky overflow flag: consumed by the trailer, but a drop in that same cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= drop_s || (ovf_r && !close_s);
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    // Wrapping count of trailers that left the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'h0000;
        end else if ((state_r == TRL) && xfer_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign drop_cnt  = drop_cnt_r;
    assign frame_cnt = frame_cnt_r;
    // Derived only from the state register and the FIFO pointer registers.
    assign busy      = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_dsp_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_dsp_frame_packer
// Directed bench for dsp_frame_packer (FRAME_LEN=4, FIFO_DEPTH=8, TIMEOUT=16).
// Transferred words are collected at the falling edge and compared in order
// against hand-computed frames. DSP_PACK_CSUM_EN selects the trailer checksum.
// ---------------------------------------------------------------------------
module tb_dsp_frame_packer;

`ifdef DSP_PACK_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_iq = 32'h0;
    logic [31:0] in_time = 32'h0;
    logic        in_valid = 1'b0;
    logic [15:0] in_inter = 16'h0;
    logic        in_clr = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [15:0] drop_cnt;
    logic [15:0] frame_cnt;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [32:0] wq[$];
    int          tq[$];
    int          last_stamp = 0;
    int          iq_stamp = 0;
    bit          rnd_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [32:0] prev_word = 33'h0;

    dsp_frame_packer #(
        .FIFO_DEPTH (8),
        .FRAME_LEN  (4),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_iq     (in_iq),
        .in_time   (in_time),
        .in_valid  (in_valid),
        .in_inter  (in_inter),
        .in_clr    (in_clr),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .drop_cnt  (drop_cnt),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] trl(input logic [15:0] cs, input logic [15:0] low);
        return {(CSUM_ON ? cs : 16'h0000), low};
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: records transfers and checks words are held during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold", {1'b0, m_valid, m_last, m_data}, {2'b01, prev_word});
            end
            if (m_valid && m_ready) begin
                wq.push_back({m_last, m_data});
                tq.push_back(cyc);
            end
            stall_prev = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
        end
    end

    // Random sink backpressure when enabled.
    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] iq, input logic [31:0] tm, input logic [15:0] it);
        in_iq    = iq;
        in_time  = tm;
        in_inter = it;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic l);
        int          n;
        logic [32:0] w;
        n = 0;
        while (wq.size() == 0 && n < 400) begin
            tick(1);
            n++;
        end
        if (wq.size() != 0) begin
            w          = wq.pop_front();
            last_stamp = tq.pop_front();
        end else begin
            w = 'x;
        end
        chk(tag, {1'b0, w}, {1'b0, l, d});
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] inter, input logic [31:0] tm,
                                input logic [31:0] iq0, input int n, input logic [31:0] trailer);
        expect_word({tag, "_hdr0"}, {16'hA5C3, inter}, 1'b0);
        expect_word({tag, "_hdr1"}, tm, 1'b0);
        for (int i = 0; i < n; i++) begin
            expect_word($sformatf("%s_iq%0d", tag, i), iq0 + 32'(i), 1'b0);
        end
        iq_stamp = last_stamp;
        expect_word({tag, "_trl"}, trailer, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick(1);
            n++;
        end
        chk(tag, 34'(busy), 34'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 34'(m_valid), 34'd0);
        chk({tag, "_last"}, 34'(m_last), 34'd0);
        chk({tag, "_data"}, 34'(m_data), 34'd0);
        chk({tag, "_drop"}, 34'(drop_cnt), 34'd0);
        chk({tag, "_frames"}, 34'(frame_cnt), 34'd0);
        chk({tag, "_busy"}, 34'(busy), 34'd0);
    endtask

    initial begin
        tick(3);
        chk_reset("rst");
        rst_n = 1'b1;
        tick(2);

        // 1: one full frame
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'(i + 1), 32'(100 + i), 16'd7);
        expect_frame("t1", 16'd7, 32'd100, 32'd1, 4, trl(16'h000A, 16'h0004));
        tick(2);
        chk("t1_frame_cnt", 34'(frame_cnt), 34'd1);

        // 2: interval change closes frame A; frame B closes on timeout
        push(32'h11, 32'd200, 16'd5);
        push(32'h12, 32'd201, 16'd5);
        push(32'h21, 32'd300, 16'd6);
        expect_frame("t2a", 16'd5, 32'd200, 32'h11, 2, trl(16'h0023, 16'h0002));
        expect_frame("t2b", 16'd6, 32'd300, 32'h21, 1, trl(16'h0021, 16'h4001));
        tick(2);
        chk("t2_frame_cnt", 34'(frame_cnt), 34'd3);

        // 3: four bursts of four samples under random backpressure
        rnd_en = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 4; i++) push(32'(32'h100 + 4 * g + i), 32'(32'h1000 + 4 * g + i), 16'd9);
            wait_idle("t3_idle");
        end
        rnd_en = 1'b0;
        tick(1);
        m_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            expect_frame($sformatf("t3f%0d", g), 16'd9, 32'(32'h1000 + 4 * g), 32'(32'h100 + 4 * g), 4,
                         trl(16'(16'h0406 + 16 * g), 16'h0004));
        end
        chk("t3_drop", 34'(drop_cnt), 34'd0);
        chk("t3_frame_cnt", 34'(frame_cnt), 34'd7);

        // 4: overflow while the sink is stalled
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'(32'h30 + i), 32'(32'h3000 + i), 16'd3);
        tick(2);
        chk("t4_drop", 34'(drop_cnt), 34'd2);
        chk("t4_stall_hdr", {1'b0, m_valid, m_last, m_data}, {2'b01, 1'b0, 32'hA5C3_0003});
        m_ready = 1'b1;
        expect_frame("t4a", 16'd3, 32'h3000, 32'h30, 4, trl(16'h00C6, 16'h8004));
        expect_frame("t4b", 16'd3, 32'h3004, 32'h34, 4, trl(16'h00D6, 16'h0004));
        tick(2);
        chk("t4_frame_cnt", 34'(frame_cnt), 34'd9);
        chk("t4_drop_hold", 34'(drop_cnt), 34'd2);

        // 5: in_clr closes promptly; reset mid-frame discards it
        for (int i = 0; i < 3; i++) push(32'(32'h41 + i), 32'(32'h4000 + i), 16'd4);
        in_clr = 1'b1;
        expect_frame("t5", 16'd4, 32'h4000, 32'h41, 3, trl(16'h00C6, 16'h0003));
        chk("t5_clr_lat", (last_stamp - iq_stamp <= 2) ? 34'd1 : 34'd0, 34'd1);
        in_clr = 1'b0;
        push(32'h88, 32'h8800, 16'd8);
        expect_word("t5p_hdr0", 32'hA5C3_0008, 1'b0);
        expect_word("t5p_hdr1", 32'h8800, 1'b0);
        expect_word("t5p_iq0", 32'h88, 1'b0);
        tick(3);
        chk("t5p_busy", 34'(busy), 34'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("t5_rst");
        wq.delete();
        tq.delete();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        push(32'h55, 32'h5500, 16'd2);
        in_clr = 1'b1;
        expect_frame("t5r", 16'd2, 32'h5500, 32'h55, 1, trl(16'h0055, 16'h0001));
        in_clr = 1'b0;
        tick(2);
        chk("t5r_frame_cnt", 34'(frame_cnt), 34'd1);

        // 6: checksum over both IQ halves
        push(32'h0001_0002, 32'h600, 16'd10);
        push(32'h0003_0004, 32'h601, 16'd10);
        in_clr = 1'b1;
        expect_word("t6_hdr0", 32'hA5C3_000A, 1'b0);
        expect_word("t6_hdr1", 32'h600, 1'b0);
        expect_word("t6_iq0", 32'h0001_0002, 1'b0);
        expect_word("t6_iq1", 32'h0003_0004, 1'b0);
        expect_word("t6_trl", trl(16'h000A, 16'h0002), 1'b1);
        in_clr = 1'b0;
        tick(2);
        chk("t6_frame_cnt", 34'(frame_cnt), 34'd2);
        chk("t6_no_extra", 34'(wq.size()), 34'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
